// File: rtl/ic_download_line_pkg.sv
// Shared encodings for the instruction-cache download line: ring flit types,
// FSM state codes and default widths.
package ic_download_line_pkg;

  localparam int FLIT_W_DEF = 16;
  localparam int LINE_W_DEF = 128;

  localparam logic [1:0] CTRL_NONE = 2'b00;
  localparam logic [1:0] CTRL_HEAD = 2'b01;
  localparam logic [1:0] CTRL_BODY = 2'b10;
  localparam logic [1:0] CTRL_TAIL = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RECV = 2'b01;
  localparam logic [1:0] ST_FULL = 2'b10;

endpackage

// File: rtl/ic_download_line_flit_assembler.sv
// ic_flit_assembler: flit counter plus indexed write into the line register.
// Also takes a whole-line load from local memory and a clear-to-zero.
module ic_flit_assembler #(
  parameter int FLIT_W = 16,
  parameter int LINE_W = 128,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic              clr,
  input  logic              zero,
  input  logic              ld_en,
  input  logic [LINE_W-1:0] ld_line,
  input  logic [FLIT_W-1:0] flit,
  output logic [LINE_W-1:0] line,
  output logic [CNT_W-1:0]  cnt,
  output logic              full
);

  localparam int NFLITS = LINE_W / FLIT_W;

  // Writes past the last flit slot are silently dropped.
  assign full = (cnt == CNT_W'(NFLITS));

  always_ff @(posedge clk) begin
    if (rst) begin
      line <= '0;
      cnt  <= '0;
    end else begin
      if (ld_en)
        line <= ld_line;
      else if (zero)
        line <= '0;
      else if (wr_en && !full)
        line[int'(cnt)*FLIT_W +: FLIT_W] <= flit;

      if (clr)
        cnt <= '0;
      else if (wr_en && !full)
        cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ic_download_line.sv
// Instruction-cache download line: builds a cache line from local memory or a
// ring reply packet. Define IC_DL_ERR_CHK_EN for protocol error checking.
module ic_download_line
  import ic_download_line_pkg::*;
#(
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int LINE_W = LINE_W_DEF,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] rep_flit_ic,
  input  logic              v_rep_flit_ic,
  input  logic [1:0]        rep_ctrl_ic,
  output logic              rep_ack_ic,
  input  logic [LINE_W-1:0] mem_flits_ic,
  input  logic              v_mem_flits_ic,
  output logic              mem_ack_ic,
  output logic [LINE_W-1:0] inst_line_ic,
  output logic              v_inst_line,
  input  logic              inst_ready,
  output logic              ic_download_state,
  output logic              err_ic
);

  localparam int NFLITS = LINE_W / FLIT_W;

  logic [1:0]       state, state_nxt;
  logic             asm_wr, asm_clr, asm_zero, asm_ld;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             flit_ok, is_head, is_tail;

  assign flit_ok = v_rep_flit_ic && (rep_ctrl_ic != CTRL_NONE);
  assign is_head = (rep_ctrl_ic == CTRL_HEAD);
  assign is_tail = (rep_ctrl_ic == CTRL_TAIL);

`ifdef IC_DL_ERR_CHK_EN
  logic err_nxt, ovf, ovf_nxt;
`endif

  always_comb begin
    state_nxt  = state;
    rep_ack_ic = 1'b0;
    mem_ack_ic = 1'b0;
    asm_wr     = 1'b0;
    asm_clr    = 1'b0;
    asm_zero   = 1'b0;
    asm_ld     = 1'b0;
`ifdef IC_DL_ERR_CHK_EN
    err_nxt    = 1'b0;
    ovf_nxt    = ovf;
`endif
    case (state)
      ST_IDLE: begin
        if (v_mem_flits_ic) begin
          mem_ack_ic = 1'b1;
          asm_ld     = 1'b1;
          state_nxt  = ST_FULL;
        end else if (flit_ok) begin
          rep_ack_ic = 1'b1;
          if (is_head) begin
            asm_clr   = 1'b1;
            state_nxt = ST_RECV;
`ifdef IC_DL_ERR_CHK_EN
            asm_zero  = 1'b1;
            ovf_nxt   = 1'b0;
`endif
          end
        end
      end
      ST_RECV: begin
        if (flit_ok) begin
          rep_ack_ic = 1'b1;
`ifdef IC_DL_ERR_CHK_EN
          if (is_head) begin
            asm_clr  = 1'b1;
            asm_zero = 1'b1;
            ovf_nxt  = 1'b0;
            err_nxt  = 1'b1;
          end else if (is_tail) begin
            asm_wr  = 1'b1;
            asm_clr = 1'b1;
            ovf_nxt = 1'b0;
            if (full) begin
              // An earlier dropped body already flagged the error.
              err_nxt   = !ovf;
              state_nxt = ST_IDLE;
            end else if (cnt != CNT_W'(NFLITS - 1)) begin
              err_nxt   = 1'b1;
              state_nxt = ST_IDLE;
            end else begin
              state_nxt = ST_FULL;
            end
          end else begin
            asm_wr = 1'b1;
            if (full) begin
              err_nxt = 1'b1;
              ovf_nxt = 1'b1;
            end
          end
`else
          asm_wr = 1'b1;
          if (is_tail) begin
            asm_clr   = 1'b1;
            state_nxt = ST_FULL;
          end
`endif
        end
      end
      ST_FULL: begin
        if (inst_ready)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

`ifdef IC_DL_ERR_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_ic <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      err_ic <= err_nxt;
      ovf    <= ovf_nxt;
    end
  end
`else
  assign err_ic = 1'b0;
`endif

  ic_flit_assembler #(
    .FLIT_W (FLIT_W),
    .LINE_W (LINE_W),
    .CNT_W  (CNT_W)
  ) u_asm (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (asm_wr),
    .clr     (asm_clr),
    .zero    (asm_zero),
    .ld_en   (asm_ld),
    .ld_line (mem_flits_ic),
    .flit    (rep_flit_ic),
    .line    (inst_line_ic),
    .cnt     (cnt),
    .full    (full)
  );

  assign v_inst_line       = (state == ST_FULL);
  assign ic_download_state = (state != ST_IDLE);

endmodule

// File: tb/tb_ic_download_line.sv
// Directed self-checking bench for ic_download_line (both IC_DL_ERR_CHK_EN builds).
module tb_ic_download_line;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  rep_flit_ic;
  logic         v_rep_flit_ic;
  logic [1:0]   rep_ctrl_ic;
  logic         rep_ack_ic;
  logic [127:0] mem_flits_ic;
  logic         v_mem_flits_ic;
  logic         mem_ack_ic;
  logic [127:0] inst_line_ic;
  logic         v_inst_line;
  logic         inst_ready;
  logic         ic_download_state;
  logic         err_ic;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ic_download_line dut (
    .clk               (clk),
    .rst               (rst),
    .rep_flit_ic       (rep_flit_ic),
    .v_rep_flit_ic     (v_rep_flit_ic),
    .rep_ctrl_ic       (rep_ctrl_ic),
    .rep_ack_ic        (rep_ack_ic),
    .mem_flits_ic      (mem_flits_ic),
    .v_mem_flits_ic    (v_mem_flits_ic),
    .mem_ack_ic        (mem_ack_ic),
    .inst_line_ic      (inst_line_ic),
    .v_inst_line       (v_inst_line),
    .inst_ready        (inst_ready),
    .ic_download_state (ic_download_state),
    .err_ic            (err_ic)
  );

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one flit for one cycle, checking the combinational ack.
  task automatic send(input logic [1:0] c, input logic [15:0] d, input logic exp_ack);
    v_rep_flit_ic = 1'b1;
    rep_ctrl_ic   = c;
    rep_flit_ic   = d;
    #1;
    check_eq("rep_ack", rep_ack_ic, exp_ack);
    tick();
    v_rep_flit_ic = 1'b0;
    rep_ctrl_ic   = 2'b00;
  endtask

  // Seven bodies base+1..base+7 and tail base+8.
  task automatic send_data(input logic [15:0] base);
    for (int k = 1; k <= 7; k++) begin
      send(2'b10, base + 16'(k), 1'b1);
      check_eq("v_line_in_recv", v_inst_line, 1'b0);
    end
    send(2'b11, base + 16'd8, 1'b1);
  endtask

  task automatic handshake;
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    check_eq("hs_idle", ic_download_state, 1'b0);
  endtask

  logic [127:0] exp_line;

  initial begin
    rst = 1'b1; rep_flit_ic = '0; v_rep_flit_ic = 1'b0; rep_ctrl_ic = 2'b00;
    mem_flits_ic = '0; v_mem_flits_ic = 1'b0; inst_ready = 1'b0;
    tick(); tick();
    check_eq("rst_v_line", v_inst_line, 1'b0);
    check_eq("rst_state", ic_download_state, 1'b0);
    check_eq("rst_err", err_ic, 1'b0);
    check_eq("rst_line", inst_line_ic, 128'h0);
    rst = 1'b0;
    tick();

    // memory path
    mem_flits_ic = 128'h12345678_12345678_12345678_12345678;
    v_mem_flits_ic = 1'b1;
    #1;
    check_eq("mem_ack", mem_ack_ic, 1'b1);
    check_eq("mem_rep_ack", rep_ack_ic, 1'b0);
    tick();
    v_mem_flits_ic = 1'b0;
    check_eq("mem_v_line", v_inst_line, 1'b1);
    check_eq("mem_line", inst_line_ic, 128'h12345678_12345678_12345678_12345678);
    handshake();
    check_eq("mem_v_line_off", v_inst_line, 1'b0);

    // ring path
    send(2'b01, 16'hAAAA, 1'b1);
    check_eq("ring_busy", ic_download_state, 1'b1);
    check_eq("ring_v_head", v_inst_line, 1'b0);
    send_data(16'h0000);
    check_eq("ring_v_line", v_inst_line, 1'b1);
    check_eq("ring_line", inst_line_ic, 128'h0008_0007_0006_0005_0004_0003_0002_0001);

    // back-pressure with a head waiting
    v_rep_flit_ic = 1'b1; rep_ctrl_ic = 2'b01; rep_flit_ic = 16'hBEEF;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("bp_rep_ack", rep_ack_ic, 1'b0);
      check_eq("bp_line", inst_line_ic, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
      tick();
    end
    inst_ready = 1'b1;
    #1;
    check_eq("bp_rep_ack_full", rep_ack_ic, 1'b0);
    tick();
    inst_ready = 1'b0;
    check_eq("bp_hold_line", inst_line_ic, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
    send(2'b01, 16'hBEEF, 1'b1);
    send_data(16'h1100);
    check_eq("bp_line2", inst_line_ic, 128'h1108_1107_1106_1105_1104_1103_1102_1101);
    handshake();

    // collision: memory wins
    mem_flits_ic = 128'hCAFEF00D_DEADBEEF_01234567_89ABCDEF;
    v_mem_flits_ic = 1'b1;
    v_rep_flit_ic = 1'b1; rep_ctrl_ic = 2'b01; rep_flit_ic = 16'h5555;
    #1;
    check_eq("col_mem_ack", mem_ack_ic, 1'b1);
    check_eq("col_rep_ack", rep_ack_ic, 1'b0);
    tick();
    v_mem_flits_ic = 1'b0;
    check_eq("col_line", inst_line_ic, 128'hCAFEF00D_DEADBEEF_01234567_89ABCDEF);
    #1;
    check_eq("col_rep_ack_full", rep_ack_ic, 1'b0);
    handshake();
    send(2'b01, 16'h5555, 1'b1);
    send_data(16'h2200);
    check_eq("col_ring_line", inst_line_ic, 128'h2208_2207_2206_2205_2204_2203_2202_2201);
    handshake();

    // stray body and ctrl none in IDLE
    send(2'b10, 16'h9999, 1'b1);
    check_eq("stray_idle", ic_download_state, 1'b0);
    send(2'b00, 16'h9999, 1'b0);
    check_eq("none_idle", ic_download_state, 1'b0);

    // short packet
    send(2'b01, 16'hAAAA, 1'b1);
    send(2'b10, 16'hB001, 1'b1);
    send(2'b10, 16'hB002, 1'b1);
    send(2'b10, 16'hB003, 1'b1);
    send(2'b11, 16'hB004, 1'b1);
`ifdef IC_DL_ERR_CHK_EN
    check_eq("short_err", err_ic, 1'b1);
    check_eq("short_v_line", v_inst_line, 1'b0);
    check_eq("short_idle", ic_download_state, 1'b0);
    tick();
    check_eq("short_err_pulse", err_ic, 1'b0);
    check_eq("short_v_line2", v_inst_line, 1'b0);
`else
    exp_line = 128'h2208_2207_2206_2205_2204_2203_2202_2201;
    exp_line[63:0] = 64'hB004_B003_B002_B001;
    check_eq("short_err", err_ic, 1'b0);
    check_eq("short_v_line", v_inst_line, 1'b1);
    check_eq("short_line", inst_line_ic, exp_line);
    handshake();
`endif

    // over-long packet
    send(2'b01, 16'hAAAA, 1'b1);
    for (int k = 1; k <= 8; k++)
      send(2'b10, 16'hC000 + 16'(k), 1'b1);
    send(2'b10, 16'hC009, 1'b1);
`ifdef IC_DL_ERR_CHK_EN
    check_eq("ovf_err", err_ic, 1'b1);
    send(2'b11, 16'hC00A, 1'b1);
    check_eq("ovf_err_tail", err_ic, 1'b0);
    check_eq("ovf_idle", ic_download_state, 1'b0);
    check_eq("ovf_v_line", v_inst_line, 1'b0);
`else
    check_eq("ovf_err", err_ic, 1'b0);
    send(2'b11, 16'hC00A, 1'b1);
    check_eq("ovf_v_line", v_inst_line, 1'b1);
    check_eq("ovf_line", inst_line_ic, 128'hC008_C007_C006_C005_C004_C003_C002_C001);
    handshake();
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
